// File: rtl/timed_decoder_if.sv
// rtl/timed_decoder_if.sv - request/one-hot bus for timed_decoder; TIMED_DECODER_ERR_EN adds err
interface timed_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
);
  logic               enable;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in;
  logic [NUM_OUT-1:0] out;
  logic               busy;
  logic               done;
`ifdef TIMED_DECODER_ERR_EN
  logic               err;

  modport master (output enable, in_valid, in, input in_ready, out, busy, done, err);
  modport slave  (input enable, in_valid, in, output in_ready, out, busy, done, err);
`else
  modport master (output enable, in_valid, in, input in_ready, out, busy, done);
  modport slave  (input enable, in_valid, in, output in_ready, out, busy, done);
`endif
endinterface

// File: rtl/timed_decoder.sv
// rtl/timed_decoder.sv - one-hot decoder holding each output HOLD cycles; TIMED_DECODER_ERR_EN adds err pulse
module timed_decoder #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int HOLD    = 4
) (
  input  logic            clk,
  input  logic            rst,
  timed_decoder_if.slave  bus
);

  localparam int               CNT_W     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(HOLD - 1);
  localparam logic [31:0]      NUM_OUT_U = 32'(NUM_OUT);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [NUM_OUT-1:0] r_out, w_out_nxt;
  logic [NUM_OUT-1:0] w_onehot;
  logic               w_last;
  logic               w_accept;
  logic               w_in_range;

  assign w_last     = (r_state == S_HOLD) && (r_count == '0);
  assign w_accept   = bus.in_valid & bus.in_ready;
  assign w_in_range = 32'(bus.in) < NUM_OUT_U;
  assign w_onehot   = {{(NUM_OUT-1){1'b0}}, 1'b1} << bus.in;

  assign bus.in_ready = bus.enable & ~rst & ((r_state == S_IDLE) | w_last);
  assign bus.out      = r_out;
  assign bus.busy     = (r_state == S_HOLD);
  assign bus.done     = w_last & bus.enable & ~rst;

  // State, count and output register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Next state: disable aborts, acceptance (re)loads, otherwise count down then release
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_out_nxt   = r_out;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_in_range) begin
          w_state_nxt = S_HOLD;
          w_count_nxt = CNT_LOAD;
          w_out_nxt   = w_onehot;
        end
      end
      S_HOLD: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
          w_out_nxt   = '0;
        end else if (r_count != '0) begin
          w_count_nxt = r_count - CNT_W'(1);
        end else if (w_accept && w_in_range) begin
          w_count_nxt = CNT_LOAD;
          w_out_nxt   = w_onehot;
        end else begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
          w_out_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
        w_out_nxt   = '0;
      end
    endcase
  end

`ifdef TIMED_DECODER_ERR_EN
  logic r_err;

  assign bus.err = r_err;

  // One-cycle flag after an out-of-range select is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_in_range;
    end
  end
`endif

endmodule

// File: tb/tb_timed_decoder.sv
// tb/tb_timed_decoder.sv - directed self-checking bench for timed_decoder
module tb_timed_decoder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  timed_decoder_if #(.SEL_W(3), .NUM_OUT(8)) bus8 ();
  timed_decoder_if #(.SEL_W(3), .NUM_OUT(6)) bus6 ();

  timed_decoder #(.SEL_W(3), .NUM_OUT(8), .HOLD(4)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  timed_decoder #(.SEL_W(3), .NUM_OUT(6), .HOLD(4)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  task automatic test_reset();
    rst = 1'b1;
    bus8.enable = 1'b1; bus8.in_valid = 1'b1; bus8.in = 3'd4;
    bus6.enable = 1'b1; bus6.in_valid = 1'b1; bus6.in = 3'd2;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus8.out, bus8.busy, bus8.done, bus8.in_ready} !== 11'h000) begin
      errors++;
      $display("FAIL reset8 {out,busy,done,rdy}=%h expected 000", {bus8.out, bus8.busy, bus8.done, bus8.in_ready});
    end
    checks++;
    if ({bus6.out, bus6.busy, bus6.done, bus6.in_ready} !== 9'h000) begin
      errors++;
      $display("FAIL reset6 {out,busy,done,rdy}=%h expected 000", {bus6.out, bus6.busy, bus6.done, bus6.in_ready});
    end
`ifdef TIMED_DECODER_ERR_EN
    checks++;
    if (bus6.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err err=%b expected 0", bus6.err);
    end
`endif
    rst = 1'b0;
    bus8.in_valid = 1'b0;
    bus6.in_valid = 1'b0;
    bus8.enable = 1'b0;
    #1;
    checks++;
    if (bus8.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_dis_rdy in_ready=%b expected 0", bus8.in_ready);
    end
  endtask

  task automatic test_disabled();
    bus8.enable = 1'b0; bus8.in_valid = 1'b1; bus8.in = 3'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus8.out, bus8.busy, bus8.done, bus8.in_ready} !== 11'h000) begin
        errors++;
        $display("FAIL disabled cyc%0d {out,busy,done,rdy}=%h expected 000", k,
                 {bus8.out, bus8.busy, bus8.done, bus8.in_ready});
      end
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] e_out;
    logic       e_busy, e_done, e_rdy;
    @(negedge clk);
    bus8.enable = 1'b1; bus8.in = 3'd5; bus8.in_valid = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_rdy in_ready=%b expected 1", bus8.in_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e_out  = (k <= 4) ? 8'h20 : 8'h00;
      e_busy = (k <= 4);
      e_done = (k == 4);
      e_rdy  = (k >= 4);
      checks++;
      if ({bus8.out, bus8.busy, bus8.done, bus8.in_ready} !== {e_out, e_busy, e_done, e_rdy}) begin
        errors++;
        $display("FAIL single cyc%0d out=%h busy=%b done=%b rdy=%b expected out=%h busy=%b done=%b rdy=%b",
                 k, bus8.out, bus8.busy, bus8.done, bus8.in_ready, e_out, e_busy, e_done, e_rdy);
      end
      bus8.in_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e_out;
    logic       e_busy, e_done, e_rdy;
    bus8.enable = 1'b1; bus8.in = 3'd2; bus8.in_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e_out  = (k <= 4) ? 8'h04 : ((k <= 8) ? 8'h80 : 8'h00);
      e_busy = (k <= 8);
      e_done = (k == 4) || (k == 8);
      e_rdy  = (k == 4) || (k >= 8);
      checks++;
      if ({bus8.out, bus8.busy, bus8.done, bus8.in_ready} !== {e_out, e_busy, e_done, e_rdy}) begin
        errors++;
        $display("FAIL b2b cyc%0d out=%h busy=%b done=%b rdy=%b expected out=%h busy=%b done=%b rdy=%b",
                 k, bus8.out, bus8.busy, bus8.done, bus8.in_ready, e_out, e_busy, e_done, e_rdy);
      end
      if (k == 1) bus8.in_valid = 1'b0;
      if (k == 4) begin bus8.in = 3'd7; bus8.in_valid = 1'b1; end
      if (k == 5) bus8.in_valid = 1'b0;
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] e_out;
    logic       e_busy, e_done, e_rdy;
    bus8.enable = 1'b1; bus8.in = 3'd1; bus8.in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e_out  = (k <= 2) ? 8'h02 : 8'h00;
      e_busy = (k <= 2);
      checks++;
      if ({bus8.out, bus8.busy, bus8.done, bus8.in_ready} !== {e_out, e_busy, 2'b00}) begin
        errors++;
        $display("FAIL endrop cyc%0d out=%h busy=%b done=%b rdy=%b expected out=%h busy=%b done=0 rdy=0",
                 k, bus8.out, bus8.busy, bus8.done, bus8.in_ready, e_out, e_busy);
      end
      bus8.in_valid = 1'b0;
      if (k == 2) bus8.enable = 1'b0;
    end
    bus8.enable = 1'b1; bus8.in = 3'd1; bus8.in_valid = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      e_out  = (j <= 4) ? 8'h02 : 8'h00;
      e_busy = (j <= 4);
      e_done = (j == 4);
      e_rdy  = (j == 4);
      checks++;
      if ({bus8.out, bus8.busy, bus8.done, bus8.in_ready} !== {e_out, e_busy, e_done, e_rdy}) begin
        errors++;
        $display("FAIL endrop_last cyc%0d out=%h busy=%b done=%b rdy=%b expected out=%h busy=%b done=%b rdy=%b",
                 j, bus8.out, bus8.busy, bus8.done, bus8.in_ready, e_out, e_busy, e_done, e_rdy);
      end
      bus8.in_valid = 1'b0;
      if (j == 4) begin
        bus8.enable = 1'b0;
        #1;
        checks++;
        if ({bus8.done, bus8.in_ready} !== 2'b00) begin
          errors++;
          $display("FAIL endrop_done done=%b rdy=%b expected done=0 rdy=0", bus8.done, bus8.in_ready);
        end
      end
      if (j == 5) bus8.enable = 1'b1;
    end
  endtask

  task automatic test_out_of_range();
    logic [5:0] e_out;
    logic       e_busy, e_done, e_rdy, e_err;
    bus6.enable = 1'b1; bus6.in = 3'd6; bus6.in_valid = 1'b1;
    #1;
    checks++;
    if (bus6.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_rdy in_ready=%b expected 1", bus6.in_ready);
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if ({bus6.out, bus6.busy, bus6.done, bus6.in_ready} !== 9'h001) begin
        errors++;
        $display("FAIL oor cyc%0d {out,busy,done,rdy}=%h expected 001", k,
                 {bus6.out, bus6.busy, bus6.done, bus6.in_ready});
      end
`ifdef TIMED_DECODER_ERR_EN
      checks++;
      if (bus6.err !== (k == 1)) begin
        errors++;
        $display("FAIL oor_err cyc%0d err=%b expected %b", k, bus6.err, (k == 1));
      end
`endif
      bus6.in_valid = 1'b0;
    end
    bus6.in = 3'd5; bus6.in_valid = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      e_out  = (j <= 4) ? 6'h20 : 6'h00;
      e_busy = (j <= 4);
      e_done = (j == 4);
      e_rdy  = (j >= 4);
      e_err  = (j == 5);
      checks++;
      if ({bus6.out, bus6.busy, bus6.done, bus6.in_ready} !== {e_out, e_busy, e_done, e_rdy}) begin
        errors++;
        $display("FAIL oor_hold cyc%0d out=%h busy=%b done=%b rdy=%b expected out=%h busy=%b done=%b rdy=%b",
                 j, bus6.out, bus6.busy, bus6.done, bus6.in_ready, e_out, e_busy, e_done, e_rdy);
      end
`ifdef TIMED_DECODER_ERR_EN
      checks++;
      if (bus6.err !== e_err) begin
        errors++;
        $display("FAIL oor_hold_err cyc%0d err=%b expected %b", j, bus6.err, e_err);
      end
`else
      e_err = 1'b0;
`endif
      if (j == 1) bus6.in_valid = 1'b0;
      if (j == 4) begin bus6.in = 3'd6; bus6.in_valid = 1'b1; end
      if (j == 5) bus6.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bus8.enable = 1'b1; bus8.in = 3'd3; bus8.in_valid = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if ({bus8.out, bus8.busy, bus8.done, bus8.in_ready} !== {8'h08, 3'b100}) begin
        errors++;
        $display("FAIL rstmid cyc%0d out=%h busy=%b done=%b rdy=%b expected out=08 busy=1 done=0 rdy=0",
                 k, bus8.out, bus8.busy, bus8.done, bus8.in_ready);
      end
      bus8.in_valid = 1'b0;
    end
    rst = 1'b1;
    bus8.in = 3'd6; bus8.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus8.out, bus8.busy, bus8.done, bus8.in_ready} !== 11'h000) begin
      errors++;
      $display("FAIL rstmid_cleared {out,busy,done,rdy}=%h expected 000", {bus8.out, bus8.busy, bus8.done, bus8.in_ready});
    end
    rst = 1'b0;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus8.out, bus8.busy, bus8.done, bus8.in_ready} !== 11'h001) begin
      errors++;
      $display("FAIL rstmid_after {out,busy,done,rdy}=%h expected 001", {bus8.out, bus8.busy, bus8.done, bus8.in_ready});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_disabled();
    test_single();
    test_back_to_back();
    test_enable_drop();
    test_out_of_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timed_decoder.md
TIMED_DECODER -- requirements
Module: timed_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select width in bits.
REQ-002 SHALL have parameter NUM_OUT, default 8: number of one-hot outputs; legal range 2..2**SEL_W.
REQ-003 SHALL have parameter HOLD, default 4: number of cycles each one-hot output stays asserted; legal range >=1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  block enable; low forces idle and aborts any active hold.
REQ-007 SHALL have port in_valid  input  1  select request valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-009 SHALL have port in  input  SEL_W  select index.
REQ-010 SHALL have port out  output  NUM_OUT  registered one-hot output; bit in is set.
REQ-011 SHALL have port busy  output  1  high while a hold is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on the last cycle of a completed hold.

Function
REQ-013 SHALL implement states IDLE and HOLD; IDLE is the reset state.
REQ-014 SHALL drive in_ready = enable & !rst & (state==IDLE | (state==HOLD & count==0)), combinationally.
REQ-015 SHALL accept a request on a rising edge where in_valid & in_ready are both high.
REQ-016 SHALL, on accepting an in-range request (in < NUM_OUT), set out to (1 << in) from the next cycle. In that same update it SHALL enter HOLD with count = HOLD-1.
REQ-017 SHALL keep out stable for exactly HOLD cycles, decrementing count each cycle; count width is clog2(HOLD) with a minimum of 1.
REQ-018 SHALL assert done in the HOLD cycle where count==0 and enable is high.
REQ-019 SHALL, after a HOLD cycle with count==0 and no new acceptance, clear out to 0 and return to IDLE.
REQ-020 SHALL, on acceptance in the count==0 cycle, load the new one-hot value with no zero gap and restart count at HOLD-1. done still pulses for the finishing hold.
REQ-021 SHALL drive busy = (state==HOLD), registered.
REQ-022 SHALL, if enable is low during HOLD, clear out to 0 and return to IDLE on the next edge; done SHALL NOT pulse.
REQ-023 SHALL, for an out-of-range request (in >= NUM_OUT), complete the handshake but leave out at 0. State SHALL remain or become IDLE and done SHALL NOT pulse.
REQ-024 SHALL ignore in_valid while in_ready is low; no request is queued.

Reset
REQ-025 SHALL, while rst is high at a clock edge, set out=0, busy=0, done=0, state=IDLE and count=0; in_ready SHALL be 0 while rst is high.
REQ-026 SHALL abort an active hold on reset with no done pulse; rst SHALL take priority over all other inputs.

Configuration
REQ-027 SHALL provide macro TIMED_DECODER_ERR_EN.
REQ-028 SHALL, when TIMED_DECODER_ERR_EN is defined, add port err (output, 1 bit). err is a registered one-cycle pulse in the cycle after an out-of-range request is accepted; reset value 0. All other behaviour is per REQ-023.
REQ-029 SHALL, when TIMED_DECODER_ERR_EN is undefined, omit port err and drop out-of-range requests silently.

Verification
REQ-030 SHALL cover: enable=0, in_valid=1, in=3 for 5 cycles -> in_ready=0, out=0, busy=0, done=0 throughout.
REQ-031 SHALL cover: default params, enable=1, accept in=5 -> out=8'h20 for exactly 4 cycles, busy=1 for those cycles, done=1 on the 4th only, then out=0.
REQ-032 SHALL cover: back-to-back in=2 then in=7 accepted at count==0 -> out goes 8'h04 x4 then 8'h80 x4 with no zero cycle; done pulses twice.
REQ-033 SHALL cover: enable dropped in cycle 2 of a hold on in=1 -> out=0 next cycle, busy=0, no done.
REQ-034 SHALL cover: NUM_OUT=6, in=6 accepted -> out stays 0, no done; with TIMED_DECODER_ERR_EN, err=1 for one cycle.
REQ-035 SHALL cover: rst asserted mid-hold on in=3 -> all outputs 0 the next cycle; in_ready=1 one cycle after rst deasserts.
